// File: rtl/gate_window_if.sv
// gate_window_if: bundle of the gate_window control and status signals.
//   strobe, gate_in, enable, max_samples, holdoff, clear_status : towards the window block
//   gate_enable, window_start, sample_count, window_count,
//   truncated, missed, state_dbg                                 : from the window block
// master drives the controls (timing/config side), slave is the gate_window itself.
interface gate_window_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             strobe;
    logic             gate_in;
    logic             enable;
    logic [CNT_W-1:0] max_samples;
    logic [CNT_W-1:0] holdoff;
    logic             clear_status;
    logic             gate_enable;
    logic             window_start;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] window_count;
    logic             truncated;
    logic             missed;
    logic [2:0]       state_dbg;

    modport master (
        output strobe, gate_in, enable, max_samples, holdoff, clear_status,
        input  gate_enable, window_start, sample_count, window_count, truncated, missed,
               state_dbg
    );

    modport slave (
        input  strobe, gate_in, enable, max_samples, holdoff, clear_status,
        output gate_enable, window_start, sample_count, window_count, truncated, missed,
               state_dbg
    );
endinterface

// File: rtl/gate_window.sv
// gate_window: converts the asynchronous radar range gate into a strobe-aligned
// gate_enable level for the receive FIFO, limits samples per window, enforces an
// inter-window holdoff and keeps window/sample counters plus sticky error flags.
// Ports:
//   clock  : write-domain clock, all state on its rising edge
//   reset  : synchronous active-high reset, highest priority
//   bus    : gate_window_if slave modport (controls in, status out)
module gate_window #(
    parameter int unsigned CNT_W = 16
) (
    input logic          clock,
    input logic          reset,
    gate_window_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StPending = 3'd2,
        StActive  = 3'd3,
        StHoldoff = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             gate_meta_q, gate_s_q, gate_prev_q;
    logic             gate_enable_q, gate_enable_d;
    logic             window_start_q, window_start_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] window_count_q, window_count_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             truncated_q, truncated_d;
    logic             missed_q, missed_d;

    logic             gate_rise;
    logic             open_win, close_win, trunc_evt, missed_evt;
    logic [CNT_W-1:0] count_inc;

    assign gate_rise = gate_s_q & ~gate_prev_q;
    assign count_inc = sample_count_q + CntOne;

    always_comb begin
        state_d        = state_q;
        sample_count_d = sample_count_q;
        window_count_d = window_count_q;
        hold_cnt_d     = hold_cnt_q;
        window_start_d = 1'b0;
        open_win       = 1'b0;
        close_win      = 1'b0;
        trunc_evt      = 1'b0;
        missed_evt     = 1'b0;

        if (!bus.enable) begin
            // Counters hold; a window closed this way is not a truncation.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (gate_rise) begin
                        if (bus.strobe) open_win = 1'b1;
                        else            state_d  = StPending;
                    end
                end
                StPending: begin
                    if (gate_rise) missed_evt = 1'b1;
                    // A gate that falls before the strobe is a runt: no window.
                    if (!gate_s_q)       state_d  = StArmed;
                    else if (bus.strobe) open_win = 1'b1;
                end
                StActive: begin
                    if (bus.strobe) begin
                        if (!gate_s_q) begin
                            close_win = 1'b1;
                        end else if (bus.max_samples == '0) begin
                            // Unlimited mode saturates rather than wrapping.
                            if (sample_count_q != CntMax) sample_count_d = count_inc;
                        end else begin
                            sample_count_d = count_inc;
                            if (count_inc == bus.max_samples) begin
                                close_win = 1'b1;
                                trunc_evt = 1'b1;
                            end
                        end
                    end
                end
                StHoldoff: begin
                    if (gate_rise) missed_evt = 1'b1;
                    if (hold_cnt_q == '0)  state_d    = StArmed;
                    else if (bus.strobe)   hold_cnt_d = hold_cnt_q - CntOne;
                end
                default: state_d = StIdle;
            endcase
        end

        if (open_win) begin
            state_d        = StActive;
            window_start_d = 1'b1;
            sample_count_d = '0;
            window_count_d = window_count_q + CntOne;
        end
        if (close_win) begin
            state_d    = StHoldoff;
            hold_cnt_d = bus.holdoff;
        end

        gate_enable_d = (state_d == StActive);
        // A same-cycle error event wins over clear_status.
        truncated_d   = (truncated_q & ~bus.clear_status) | trunc_evt;
        missed_d      = (missed_q & ~bus.clear_status) | missed_evt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            gate_meta_q    <= 1'b0;
            gate_s_q       <= 1'b0;
            gate_prev_q    <= 1'b0;
            gate_enable_q  <= 1'b0;
            window_start_q <= 1'b0;
            sample_count_q <= '0;
            window_count_q <= '0;
            hold_cnt_q     <= '0;
            truncated_q    <= 1'b0;
            missed_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            gate_meta_q    <= bus.gate_in;
            gate_s_q       <= gate_meta_q;
            gate_prev_q    <= gate_s_q;
            gate_enable_q  <= gate_enable_d;
            window_start_q <= window_start_d;
            sample_count_q <= sample_count_d;
            window_count_q <= window_count_d;
            hold_cnt_q     <= hold_cnt_d;
            truncated_q    <= truncated_d;
            missed_q       <= missed_d;
        end
    end

    assign bus.gate_enable  = gate_enable_q;
    assign bus.window_start = window_start_q;
    assign bus.sample_count = sample_count_q;
    assign bus.window_count = window_count_q;
    assign bus.truncated    = truncated_q;
    assign bus.missed       = missed_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_gate_window.sv
// tb_gate_window: directed bench for gate_window. A 16-bit instance carries the main
// checks; a 4-bit instance receives identical stimulus to exercise counter wrap and
// saturation cheaply. Inputs change 2 time units after the rising edge.
module tb_gate_window;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    gate_window_if #(.CNT_W(16)) ifw ();
    gate_window_if #(.CNT_W(4))  ifn ();

    gate_window #(.CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifw.slave)
    );

    gate_window #(.CNT_W(4)) dut_n (
        .clock (clock),
        .reset (reset),
        .bus   (ifn.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ge_strobes = 0;
    int ws_pulses  = 0;
    int strobe_per = 4;
    bit strobe_run = 1'b0;
    int ph = 0;
    int base_ge, base_ws;

    // Strobe generator: one pulse every strobe_per clocks.
    initial begin
        ifw.strobe = 1'b0;
        ifn.strobe = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (ph >= strobe_per - 1) ph = 0;
            else                      ph++;
            ifw.strobe = strobe_run && (ph == strobe_per - 1);
            ifn.strobe = ifw.strobe;
        end
    end

    // Counts strobes the DUT will see while gate_enable is high, and window_start pulses.
    initial begin
        forever begin
            @(negedge clock);
            if (ifw.strobe && ifw.gate_enable) ge_strobes++;
            if (ifw.window_start) ws_pulses++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic set_gate(input logic g);
        ifw.gate_in = g;
        ifn.gate_in = g;
    endtask

    task automatic set_enable(input logic e);
        ifw.enable = e;
        ifn.enable = e;
    endtask

    task automatic set_clear(input logic c);
        ifw.clear_status = c;
        ifn.clear_status = c;
    endtask

    task automatic set_cfg(input int mx, input int ho);
        ifw.max_samples = 16'(mx);
        ifn.max_samples = 4'(mx);
        ifw.holdoff     = 16'(ho);
        ifn.holdoff     = 4'(ho);
    endtask

    task automatic pulse_clear();
        set_clear(1'b1);
        cycles(1);
        set_clear(1'b0);
    endtask

    // Returns 2 units after the edge that consumes the next strobe.
    task automatic after_strobe();
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clock);
            seen = ifw.strobe;
        end
        if (!seen) check_eq("strobe_seen", 32'(seen), 32'd1);
        @(posedge clock);
        #2;
    endtask

    task automatic wait_ge(input logic lvl, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clock);
            #2;
            ok = (ifw.gate_enable == lvl);
        end
        if (!ok) check_eq(tag, 32'(ifw.gate_enable), 32'(lvl));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ge"},    32'(ifw.gate_enable),  32'd0);
        check_eq({tag, "_ws"},    32'(ifw.window_start), 32'd0);
        check_eq({tag, "_sc"},    32'(ifw.sample_count), 32'd0);
        check_eq({tag, "_wc"},    32'(ifw.window_count), 32'd0);
        check_eq({tag, "_trunc"}, 32'(ifw.truncated),    32'd0);
        check_eq({tag, "_miss"},  32'(ifw.missed),       32'd0);
        check_eq({tag, "_state"}, 32'(ifw.state_dbg),    32'd0);
        check_eq({tag, "_wc_n"},  32'(ifn.window_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        set_enable(1'b0);
        set_gate(1'b0);
        set_cfg(0, 0);
        set_clear(1'b0);
        strobe_run = 1'b1;
        cycles(3);
        check_all_zero("reset");
        reset = 1'b0;
        cycles(1);
        check_eq("idle_state", 32'(ifw.state_dbg), 32'd0);
        set_enable(1'b1);
        cycles(1);
        check_eq("armed_state", 32'(ifw.state_dbg), 32'd1);

        // Basic window: gate high for 40 clocks, unlimited, no holdoff.
        after_strobe();
        base_ws = ws_pulses;
        set_gate(1'b1);
        cycles(3);
        check_eq("basic_pending", 32'(ifw.state_dbg), 32'd2);
        check_eq("basic_ge_pre", 32'(ifw.gate_enable), 32'd0);
        cycles(1);
        check_eq("basic_ge_open", 32'(ifw.gate_enable), 32'd1);
        check_eq("basic_ws", 32'(ifw.window_start), 32'd1);
        check_eq("basic_state", 32'(ifw.state_dbg), 32'd3);
        check_eq("basic_sc0", 32'(ifw.sample_count), 32'd0);
        check_eq("basic_wc", 32'(ifw.window_count), 32'd1);
        cycles(1);
        check_eq("basic_ws_pulse", 32'(ifw.window_start), 32'd0);
        cycles(35);
        set_gate(1'b0);
        wait_ge(1'b0, "basic_close");
        check_eq("basic_sc", 32'(ifw.sample_count), 32'd9);
        check_eq("basic_ws_count", 32'(ws_pulses - base_ws), 32'd1);
        check_eq("basic_trunc", 32'(ifw.truncated), 32'd0);
        cycles(1);
        check_eq("basic_rearm", 32'(ifw.state_dbg), 32'd1);

        // Truncation at 5 samples with the gate still high.
        set_cfg(5, 0);
        after_strobe();
        set_gate(1'b1);
        cycles(4);
        base_ge = ge_strobes;
        check_eq("trunc_ge_open", 32'(ifw.gate_enable), 32'd1);
        repeat (5) after_strobe();
        check_eq("trunc_state", 32'(ifw.state_dbg), 32'd4);
        check_eq("trunc_flag", 32'(ifw.truncated), 32'd1);
        check_eq("trunc_sc", 32'(ifw.sample_count), 32'd5);
        check_eq("trunc_ge", 32'(ifw.gate_enable), 32'd0);
        check_eq("trunc_strobes", 32'(ge_strobes - base_ge), 32'd5);
        cycles(1);
        check_eq("trunc_rearm", 32'(ifw.state_dbg), 32'd1);
        check_eq("trunc_wc", 32'(ifw.window_count), 32'd2);
        cycles(8);
        check_eq("trunc_no_reopen", 32'(ifw.gate_enable), 32'd0);
        set_gate(1'b0);
        pulse_clear();
        check_eq("trunc_cleared", 32'(ifw.truncated), 32'd0);

        // Holdoff of 3 strobes: edge after 2 strobes is missed.
        set_cfg(5, 3);
        cycles(4);
        after_strobe();
        set_gate(1'b1);
        repeat (6) after_strobe();
        check_eq("hold_state", 32'(ifw.state_dbg), 32'd4);
        set_gate(1'b0);
        repeat (2) after_strobe();
        set_gate(1'b1);
        cycles(3);
        check_eq("hold_missed", 32'(ifw.missed), 32'd1);
        check_eq("hold_still", 32'(ifw.state_dbg), 32'd4);
        cycles(3);
        check_eq("hold_rearm", 32'(ifw.state_dbg), 32'd1);
        check_eq("hold_wc_same", 32'(ifw.window_count), 32'd3);
        set_gate(1'b0);
        cycles(4);
        check_eq("hold_ge_off", 32'(ifw.gate_enable), 32'd0);
        pulse_clear();
        check_eq("hold_miss_clr", 32'(ifw.missed), 32'd0);
        // Edge 4 strobes after close opens a window.
        after_strobe();
        set_gate(1'b1);
        repeat (6) after_strobe();
        check_eq("hold2_wc", 32'(ifw.window_count), 32'd4);
        set_gate(1'b0);
        repeat (4) after_strobe();
        set_gate(1'b1);
        cycles(3);
        check_eq("hold2_pending", 32'(ifw.state_dbg), 32'd2);
        cycles(1);
        check_eq("hold2_ge", 32'(ifw.gate_enable), 32'd1);
        check_eq("hold2_wc_open", 32'(ifw.window_count), 32'd5);
        check_eq("hold2_no_miss", 32'(ifw.missed), 32'd0);

        // Runt gate between strobes (strobe every 8 clocks).
        set_cfg(0, 0);
        set_gate(1'b0);
        wait_ge(1'b0, "runt_prep_close");
        cycles(1);
        check_eq("runt_armed", 32'(ifw.state_dbg), 32'd1);
        strobe_per = 8;
        after_strobe();
        after_strobe();
        set_gate(1'b1);
        cycles(2);
        set_gate(1'b0);
        cycles(2);
        check_eq("runt_pending", 32'(ifw.state_dbg), 32'd2);
        cycles(1);
        check_eq("runt_back", 32'(ifw.state_dbg), 32'd1);
        cycles(4);
        check_eq("runt_ge", 32'(ifw.gate_enable), 32'd0);
        check_eq("runt_wc", 32'(ifw.window_count), 32'd5);
        strobe_per = 4;
        after_strobe();

        // Enable dropped mid-window.
        pulse_clear();
        after_strobe();
        set_gate(1'b1);
        wait_ge(1'b1, "en_open");
        repeat (2) after_strobe();
        cycles(1);
        check_eq("en_sc_pre", 32'(ifw.sample_count), 32'd2);
        set_enable(1'b0);
        cycles(1);
        check_eq("en_ge", 32'(ifw.gate_enable), 32'd0);
        check_eq("en_idle", 32'(ifw.state_dbg), 32'd0);
        check_eq("en_trunc", 32'(ifw.truncated), 32'd0);
        check_eq("en_sc_hold", 32'(ifw.sample_count), 32'd2);
        check_eq("en_wc_hold", 32'(ifw.window_count), 32'd6);
        set_enable(1'b1);
        cycles(12);
        check_eq("en_no_reopen", 32'(ifw.gate_enable), 32'd0);
        check_eq("en_armed", 32'(ifw.state_dbg), 32'd1);
        set_gate(1'b0);
        cycles(4);
        after_strobe();
        set_gate(1'b1);
        wait_ge(1'b1, "en_reopen");
        check_eq("en_wc_new", 32'(ifw.window_count), 32'd7);

        // Reset while ACTIVE.
        reset = 1'b1;
        cycles(1);
        check_all_zero("mid_reset");
        reset = 1'b0;
        set_gate(1'b0);
        cycles(4);

        // 16 single-sample windows: the 4-bit counter wraps to 0.
        set_cfg(1, 0);
        for (int w = 0; w < 16; w++) begin
            after_strobe();
            set_gate(1'b1);
            wait_ge(1'b1, "wrap_open");
            wait_ge(1'b0, "wrap_close");
            set_gate(1'b0);
            cycles(4);
            if (w == 14) check_eq("wrap_wc_n15", 32'(ifn.window_count), 32'd15);
        end
        check_eq("wrap_wc_n0", 32'(ifn.window_count), 32'd0);
        check_eq("wrap_wc_w16", 32'(ifw.window_count), 32'd16);

        // Unlimited mode: 19 samples saturate the 4-bit count at 15.
        set_cfg(0, 0);
        after_strobe();
        set_gate(1'b1);
        cycles(80);
        set_gate(1'b0);
        wait_ge(1'b0, "sat_close");
        check_eq("sat_sc_w", 32'(ifw.sample_count), 32'd19);
        check_eq("sat_sc_n", 32'(ifn.sample_count), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
